// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial add/subtract unit, one bit per clock, LSB first
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic           carry;
  logic [CW-1:0]  cnt;

  logic bit_a;
  logic bit_b;
  logic maj;
  logic last_bit;

  assign bit_a    = a_r[cnt];
  assign bit_b    = b_r[cnt];
  assign maj      = (bit_a & bit_b) | (bit_a & carry) | (bit_b & carry);
  assign last_bit = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_RUN;
      S_RUN:   if (last_bit) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == S_RUN);
    done = (state == S_DONE);
  end

  // Subtraction is folded into the operand latch: a - b == a + ~b + 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r   <= '0;
      b_r   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            a_r   <= a;
            b_r   <= sub ? ~b : b;
            carry <= sub ? 1'b1 : cin;
            cnt   <= '0;
          end
        end
        S_RUN: begin
          sum[cnt] <= bit_a ^ bit_b ^ carry;
          carry    <= maj;
          cnt      <= cnt + CW'(1);
          if (last_bit) cout <= maj;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - directed and random checks of serial_adder at WIDTH=8
module tb_serial_adder;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       sub;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic [7:0] sum;
  logic       cout;
  logic       busy;
  logic       done;

  int checks;
  int errors;
  int cyc;

  serial_adder #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .sub   (sub),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .sum   (sum),
    .cout  (cout),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge with the DUT idle; returns at a falling edge with the DUT idle.
  task automatic run_op(input logic [7:0] av, input logic [7:0] bv, input logic cv,
                        input logic sv, input logic [7:0] es, input logic ec, input string tag);
    int lat;
    int busy_n;
    a = av; b = bv; cin = cv; sub = sv; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    busy_n = 0;
    while (!done && lat < 30) begin
      if (busy) busy_n++;
      @(negedge clk);
      lat++;
    end
    chk(lat, 9, {tag, " latency"});
    chk(busy_n, 8, {tag, " busy cycles"});
    chk(sum, es, {tag, " sum"});
    chk(cout, ec, {tag, " cout"});
    chk(busy, 0, {tag, " busy at done"});
    @(negedge clk);
    chk(done, 0, {tag, " done width"});
  endtask

  logic [7:0] exp_s[3];
  logic       exp_c[3];
  logic [8:0] model;
  logic [7:0] ra;
  logic [7:0] rb;
  logic       rc;
  logic       rs;
  int         n;
  int         t_prev;
  int         dcount;

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0; start = 1'b0; sub = 1'b0; a = 8'h00; b = 8'h00; cin = 1'b0;
    #1;
    chk(sum, 0, "reset sum");
    chk(cout, 0, "reset cout");
    chk(busy, 0, "reset busy");
    chk(done, 0, "reset done");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, "add wrap");
    run_op(8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, "sub borrow");
    run_op(8'h07, 8'h05, 1'b0, 1'b1, 8'h02, 1'b1, "sub noborrow");
    run_op(8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, "sub ignores cin");
    run_op(8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, "add max");
    run_op(8'h00, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1, "sub zero");

    // Start and operand changes while running or finishing must be ignored.
    a = 8'h10; b = 8'h20; cin = 1'b1; sub = 1'b0; start = 1'b1;
    @(negedge clk);
    a = 8'hAA; b = 8'h55; cin = 1'b0; sub = 1'b1;
    @(negedge clk);
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!done && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk(done, 1, "ignore done");
    chk(sum, 8'h31, "ignore sum");
    chk(cout, 0, "ignore cout");
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk(busy, 0, "ignore no restart");
    dcount = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done || busy) dcount++;
    end
    chk(dcount, 0, "ignore no second op");
    chk(sum, 8'h31, "ignore sum held");

    // Reset after three bits have been processed.
    a = 8'h3C; b = 8'h0F; cin = 1'b0; sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk(sum, 0, "abort sum");
    chk(cout, 0, "abort cout");
    chk(busy, 0, "abort busy");
    chk(done, 0, "abort done");
    @(negedge clk);
    rst_n = 1'b1;
    dcount = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) dcount++;
    end
    chk(dcount, 0, "abort no done");
    run_op(8'h3C, 8'h0F, 1'b0, 1'b0, 8'h4B, 1'b0, "after abort");

    // Back-to-back operations with start held high.
    exp_s[0] = 8'h46; exp_c[0] = 1'b0;
    exp_s[1] = 8'h01; exp_c[1] = 1'b1;
    exp_s[2] = 8'hFF; exp_c[2] = 1'b0;
    t_prev = 0;
    a = 8'h12; b = 8'h34; cin = 1'b0; sub = 1'b0; start = 1'b1;
    for (int k = 0; k < 3; k++) begin
      n = 0;
      @(negedge clk);
      while (!done && n < 30) begin
        @(negedge clk);
        n++;
      end
      chk(done, 1, "b2b done");
      chk(sum, exp_s[k], "b2b sum");
      chk(cout, exp_c[k], "b2b cout");
      if (k > 0) chk(cyc - t_prev, 10, "b2b spacing");
      t_prev = cyc;
      if (k == 0) begin
        a = 8'h80; b = 8'h80; cin = 1'b1; sub = 1'b0;
      end else if (k == 1) begin
        a = 8'h00; b = 8'h01; cin = 1'b0; sub = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
    @(negedge clk);
    @(negedge clk);
    chk(busy, 0, "b2b stopped");

    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 1'($urandom);
      rs = 1'($urandom);
      if (rs) model = {1'b0, ra} + {1'b0, ~rb} + 9'd1;
      else    model = {1'b0, ra} + {1'b0, rb} + {8'd0, rc};
      run_op(ra, rb, rc, rs, model[7:0], model[8], "random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter WIDTH, default 8: operand and sum width in bits; legal range 2..32.
REQ-002 Port clk  input  1  single clock; all state changes on the rising edge.
REQ-003 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port start  input  1  request to begin an operation; sampled only in IDLE.
REQ-005 Port sub  input  1  mode: 0 = add (a + b + cin), 1 = subtract (a - b).
REQ-006 Port a  input  WIDTH  first operand; sampled with start.
REQ-007 Port b  input  WIDTH  second operand; sampled with start.
REQ-008 Port cin  input  1  carry-in for add; sampled with start; ignored when sub=1.
REQ-009 Port sum  output  WIDTH  result register.
REQ-010 Port cout  output  1  final carry; in subtract mode 1 = no borrow (a >= b unsigned).
REQ-011 Port busy  output  1  high while an operation is in progress.
REQ-012 Port done  output  1  one-cycle pulse marking valid sum/cout.

Function
REQ-013 The block SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-014 IDLE -> RUN on a clock edge with start=1; latches a, b, sub, and effective carry into internal registers.
REQ-015 On that edge: b' = ~b and carry = 1 when sub=1; b' = b and carry = cin when sub=0.
REQ-016 On that edge: bit counter is cleared to 0 and busy is set to 1.
REQ-017 In RUN, each edge SHALL process exactly one bit, LSB first, using full-adder logic.
REQ-018 Per RUN edge: sum bit = a_i ^ b'_i ^ carry; carry <= majority(a_i, b'_i, carry); counter increments.
REQ-019 The counter SHALL be ceil(log2(WIDTH)) bits wide.
REQ-020 RUN -> DONE on the edge that processes bit WIDTH-1; on that edge cout takes the final carry and busy goes to 0.
REQ-021 In DONE, done=1 for exactly one cycle; DONE -> IDLE unconditionally on the next edge.
REQ-022 Latency: start sampled at edge k gives done=1 during the cycle after edge k+WIDTH, i.e. WIDTH+1 cycles from start to done.
REQ-023 sum and cout SHALL hold their last result from DONE until the next operation begins modifying them.
REQ-024 sum bits SHALL be written in place as computed; sum is guaranteed valid only when done=1 or in IDLE after a completed operation.
REQ-025 start while busy=1 or in DONE SHALL be ignored: no restart, no operand change.
REQ-026 Operand inputs (a, b, cin, sub) SHALL have no effect on an operation in progress after the latching edge.
REQ-027 A start held high continuously SHALL launch back-to-back operations, one every WIDTH+2 cycles.
REQ-028 Arithmetic is unsigned modulo 2^WIDTH; overflow is reported only through cout, with no saturation.

Reset
REQ-029 rst_n=0 SHALL immediately, without waiting for clk, force: state IDLE; sum=0; cout=0; busy=0; done=0; counter=0; internal operand/carry registers=0.
REQ-030 Reset asserted mid-operation SHALL abort it with no done pulse.
REQ-031 After reset deassertion, the first start SHALL be accepted on the first rising edge at which rst_n=1 and start=1.

Verification (WIDTH=8)
REQ-032 a=8'hFF, b=8'h01, cin=0, sub=0, start pulse -> done at 9th cycle after start edge; sum=8'h00, cout=1; busy high for 8 cycles.
REQ-033 a=8'h05, b=8'h07, sub=1 -> sum=8'hFE, cout=0; then a=8'h07, b=8'h05, sub=1 -> sum=8'h02, cout=1.
REQ-034 Start an operation a=8'h10, b=8'h20, cin=1; pulse start with a=8'hAA during RUN and DONE -> single result sum=8'h31, cout=0; no second done.
REQ-035 Assert rst_n=0 mid-RUN (after 3 bits) -> outputs 0 at once, no done pulse; new start after release gives a correct result.
REQ-036 start held high, three operand sets -> done pulses exactly 10 cycles apart; each sum matches the reference model.
REQ-037 Random regression: 1000 operations with random a, b, cin, sub -> every result checked against a + b + cin or a - b, including cout.
